// File: rtl/bus_width_pkg.sv
// Shared sizing helpers for the bus_width_decrease serializer.
package bus_width_pkg;

  function automatic int calc_ratio(input int size_in, input int size_out);
    return size_in / size_out;
  endfunction

  // A single-beat ratio would need zero counter bits, so always keep at least one.
  function automatic int beat_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/bus_width_decrease.sv
// Wide-to-narrow serializer: one SIZE_IN word in, SIZE_IN/SIZE_OUT beats out, no output backpressure.
// Define BUS_WIDTH_DECREASE_MSB_FIRST_EN to emit the most-significant beat first (default LSB first).
module bus_width_decrease
  import bus_width_pkg::*;
#(
  parameter int SIZE_IN  = 32,
  parameter int SIZE_OUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic                input_ready,
  input  logic                input_valid,
  input  logic [SIZE_IN-1:0]  data_in,
  output logic                output_valid,
  output logic [SIZE_OUT-1:0] data_out
);

  localparam int RATIO = calc_ratio(SIZE_IN, SIZE_OUT);
  localparam int CNT_W = beat_idx_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  generate
    if ((SIZE_IN % SIZE_OUT) != 0 || RATIO < 2) begin : g_bad_params
      $error("bus_width_decrease: SIZE_IN must be a multiple of SIZE_OUT with a ratio of at least 2");
    end
  endgenerate

  logic [SIZE_IN-1:0] sr_q,   sr_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               last_beat;
  logic [SIZE_OUT-1:0] beat_w [RATIO];

  assign last_beat   = (cnt_q == LAST_BEAT);
  assign input_ready = !busy_q || last_beat;
  assign accept      = input_valid && input_ready;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (accept) begin
      sr_d   = data_in;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Counter parks on the last beat when idle so data_out keeps showing it.
      if (last_beat) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_beat
`ifdef BUS_WIDTH_DECREASE_MSB_FIRST_EN
      assign beat_w[gi] = sr_q[SIZE_IN-1-gi*SIZE_OUT -: SIZE_OUT];
`else
      assign beat_w[gi] = sr_q[gi*SIZE_OUT +: SIZE_OUT];
`endif
    end
  endgenerate

  assign output_valid = busy_q;
  assign data_out     = beat_w[cnt_q];

endmodule

// File: tb/tb_bus_width_decrease.sv
// Directed and randomized checks for bus_width_decrease (32-bit in, 8-bit beats out).
module tb_bus_width_decrease;

  localparam int SIN  = 32;
  localparam int SOUT = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            input_ready;
  logic            input_valid;
  logic [SIN-1:0]  data_in;
  logic            output_valid;
  logic [SOUT-1:0] data_out;

  int n_vec  = 0;
  int n_miss = 0;

  bus_width_decrease #(.SIZE_IN(SIN), .SIZE_OUT(SOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_ready  (input_ready),
    .input_valid  (input_valid),
    .data_in      (data_in),
    .output_valid (output_valid),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
`ifdef BUS_WIDTH_DECREASE_MSB_FIRST_EN
    return w[31-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  logic [7:0] exp_q[$];

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    int          acc;
    int          cyc;
    logic        hold;

    reset       = 1'b0;
    input_valid = 1'b0;
    data_in     = '0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_ovalid", 32'(output_valid), 32'd0);
    check_vec("rst_dout",   32'(data_out),     32'd0);
    reset = 1'b1;
    #1;
    check_vec("rst_ready",  32'(input_ready),  32'd1);

    // 2. single word
    tick();
    w0 = 32'hA1B2C3D4;
    input_valid = 1'b1;
    data_in     = w0;
    check_vec("single_ready_idle", 32'(input_ready), 32'd1);
    tick();
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("single_ov%0d", k),    32'(output_valid), 32'd1);
      check_vec($sformatf("single_beat%0d", k),  32'(data_out),     32'(exp_beat(w0, k)));
      check_vec($sformatf("single_ready%0d", k), 32'(input_ready),  (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check_vec("single_ov_end",   32'(output_valid), 32'd0);
    check_vec("single_dout_hold", 32'(data_out),    32'(exp_beat(w0, 3)));

    // 3. back-to-back words with valid held high
    w0 = 32'h03020100;
    w1 = 32'h07060504;
    input_valid = 1'b1;
    data_in     = w0;
    tick();
    data_in = w1;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("b2b_w0_ov%0d", k),   32'(output_valid), 32'd1);
      check_vec($sformatf("b2b_w0_beat%0d", k), 32'(data_out),     32'(exp_beat(w0, k)));
      tick();
    end
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("b2b_w1_ov%0d", k),   32'(output_valid), 32'd1);
      check_vec($sformatf("b2b_w1_beat%0d", k), 32'(data_out),     32'(exp_beat(w1, k)));
      tick();
    end
    check_vec("b2b_ov_end", 32'(output_valid), 32'd0);

    // 4. valid while not ready is ignored until the ready edge
    w0 = 32'hCAFEF00D;
    w1 = 32'hDEADBEEF;
    input_valid = 1'b1;
    data_in     = w0;
    tick();
    data_in = w1;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("ign_w0_beat%0d", k), 32'(data_out), 32'(exp_beat(w0, k)));
      tick();
    end
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("ign_w1_beat%0d", k), 32'(data_out), 32'(exp_beat(w1, k)));
      tick();
    end
    check_vec("ign_ov_end", 32'(output_valid), 32'd0);

    // 5. reset in the middle of a word
    w0 = 32'h11223344;
    input_valid = 1'b1;
    data_in     = w0;
    tick();
    input_valid = 1'b0;
    check_vec("rmid_beat0", 32'(data_out), 32'(exp_beat(w0, 0)));
    tick();
    check_vec("rmid_beat1", 32'(data_out), 32'(exp_beat(w0, 1)));
    #2;
    reset = 1'b0;
    #1;
    check_vec("rmid_ov_async", 32'(output_valid), 32'd0);
    check_vec("rmid_dout_clr", 32'(data_out),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_vec("rmid_ready", 32'(input_ready), 32'd1);
    tick();
    check_vec("rmid_no_tail", 32'(output_valid), 32'd0);
    w1 = 32'h55667788;
    input_valid = 1'b1;
    data_in     = w1;
    tick();
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("rmid_w1_beat%0d", k), 32'(data_out), 32'(exp_beat(w1, k)));
      tick();
    end
    check_vec("rmid_ov_end", 32'(output_valid), 32'd0);

    // 6. random words with random valid gaps, checked against a beat scoreboard
    acc  = 0;
    cyc  = 0;
    hold = 1'b0;
    while (acc < 20 && cyc < 2000) begin
      if (output_valid) begin
        if (exp_q.size() == 0) check_vec("rand_extra_beat", 32'd1, 32'd0);
        else                   check_vec("rand_beat", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (!hold) begin
        input_valid = ($urandom_range(0, 2) != 0);
        data_in     = $urandom;
      end
      if (input_valid && input_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_beat(data_in, k));
        acc++;
        hold = 1'b0;
      end else begin
        hold = input_valid;
      end
      tick();
      cyc++;
    end
    input_valid = 1'b0;
    repeat (6) begin
      if (output_valid) begin
        if (exp_q.size() == 0) check_vec("rand_extra_beat", 32'd1, 32'd0);
        else                   check_vec("rand_beat", 32'(data_out), 32'(exp_q.pop_front()));
      end
      tick();
    end
    check_vec("rand_accepted", 32'(acc), 32'd20);
    check_vec("rand_drained",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_width_decrease.md
Name: bus_width_decrease

Overview:
- Width-down serializer. Accepts one SIZE_IN-bit word per valid/ready handshake and emits it as RATIO = SIZE_IN/SIZE_OUT consecutive SIZE_OUT-bit beats, one beat per cycle.
- Sits between a wide producer (e.g. 32-bit FIFO read side) and a narrow consumer (e.g. 8-bit byte stream / UART TX).
- The output side has no backpressure: the consumer must take every beat flagged by output_valid.

Parameters:
- SIZE_IN, 32, input word width in bits; must be a multiple of SIZE_OUT.
- SIZE_OUT, 8, output beat width in bits; RATIO = SIZE_IN/SIZE_OUT must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- input_ready  output  1  block can accept a word this cycle.
- input_valid  input  1  data_in holds a valid word.
- data_in  input  SIZE_IN  wide input word.
- output_valid  output  1  data_out holds a valid beat this cycle.
- data_out  output  SIZE_OUT  narrow output beat.

Behaviour:
- State:
  - shift/holding register sr[SIZE_IN-1:0].
  - beat counter cnt, $clog2(RATIO) bits.
  - busy flag.
  - All registered.
- Reset (reset=0, async): busy=0, cnt=0, sr=0, output_valid=0, data_out=0. input_ready goes to 1 once reset deasserts, as a combinational function of state.
- input_ready = !busy || (cnt == RATIO-1). It depends on state only, never on input_valid.
- Accept: a word is accepted on a rising edge when input_valid && input_ready.
  - Next cycle: sr=data_in, cnt=0, busy=1.
- Beat emission:
  - While busy, output_valid=1 and data_out = beat cnt of sr.
  - Default order is LSB first: beat k = sr[k*SIZE_OUT +: SIZE_OUT].
  - cnt increments each cycle.
- Last beat (cnt==RATIO-1):
  - If input_valid is high, a new word is accepted on that edge and its beat 0 follows immediately. No bubble, so output_valid stays 1 continuously (100% output throughput).
  - If input_valid is low, busy clears and output_valid=0 next cycle.
- Latency: one cycle from the accepting edge to beat 0 on data_out.
- output_valid=0 implies data_out holds its last value. Consumers must ignore data_out while output_valid=0.
- input_valid while input_ready=0 is ignored. The producer must hold the word until the handshake completes.
- Reset asserted mid-word aborts the word immediately: the remaining beats are discarded and output_valid drops asynchronously.
- RATIO boundaries: the counter wraps only by reload on accept, never by free-running.

Optional Feature:
- Macro BUS_WIDTH_DECREASE_MSB_FIRST_EN.
  - Defined: beats are emitted most-significant first, beat k = sr[SIZE_IN-1-k*SIZE_OUT -: SIZE_OUT].
  - Undefined: LSB first, as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Package bus_width_pkg:
  - localparam function calc_ratio(in,out).
  - Beat-index width helper.
- No sub-module needed. The counter and shift register stay inline.

Test Plan:
1. Reset: hold reset=0 for 2 cycles -> output_valid=0, data_out=0; after release, input_ready=1.
2. Single word: data_in=32'hA1B2C3D4, one-cycle valid -> beats D4,C3,B2,A1 on 4 consecutive cycles with output_valid=1, then output_valid=0. input_ready is 0 during beats 0-2 and 1 on beat 3. With the MSB_FIRST macro defined: A1,B2,C3,D4.
3. Back-to-back: input_valid held 1 with 32'h03020100 then 32'h07060504 -> 8 contiguous beats 00..07, output_valid never drops.
4. Ignored valid: change data_in to 32'hDEADBEEF with input_valid=1 while input_ready=0 -> the current word finishes unchanged; DEADBEEF is accepted only at the ready edge.
5. Reset mid-word: assert reset after beat 1 of 32'h11223344 -> output_valid=0 immediately; after release, the next word 32'h55667788 yields 88,77,66,55 only.
6. Random: 20 $urandom words with random input_valid gaps -> the reassembled beat stream matches the accepted word sequence exactly.
